// File: rtl/joy_chain_decoder.sv
// rtl/joy_chain_decoder.sv - serial joystick shift-register chain scanner
// Loads the chain, clocks out NUM_CH*BITS_PER_CH bits MSB first and commits whole frames.
module joy_chain_decoder #(
   parameter int NUM_CH      = 2,
   parameter int BITS_PER_CH = 8,
   parameter int CLK_DIV     = 16,
   parameter int SEL_MODE    = 0,
   parameter int INVERT      = 0
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic                          joy_data_i,
   output logic                          joy_clk_o,
   output logic                          joy_load_o,
   output logic                          joy_sel_o,
   output logic [NUM_CH*BITS_PER_CH-1:0] joy_o,
   output logic [NUM_CH*BITS_PER_CH-1:0] joy_alt_o,
   output logic                          frame_o
);

   localparam int N     = NUM_CH * BITS_PER_CH;
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
   localparam logic [N-1:0]     INV_MASK = (INVERT != 0) ? {N{1'b1}} : {N{1'b0}};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      COMMIT,
      SETTLE
   } state_t;

   state_t           state_q, state_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [N-1:0]     cap_q, cap_d;
   logic [N-1:0]     joy_q, joy_d;
   logic [N-1:0]     alt_q, alt_d;
   logic             clk_q, clk_d;
   logic             load_q, load_d;
   logic             sel_q, sel_d;
   logic             frame_q, frame_d;

   logic             tick;
   logic [N-1:0]     cap_shift;

   // New bit enters at the LSB so the first bit received ends up in bit N-1.
   generate
      if (N == 1) begin : g_shift_one
         assign cap_shift = joy_data_i;
      end else begin : g_shift_many
         assign cap_shift = {cap_q[N-2:0], joy_data_i};
      end
   endgenerate

   assign tick = (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      div_d   = tick ? '0 : div_q + DIV_W'(1);
      cnt_d   = cnt_q;
      cap_d   = cap_q;
      joy_d   = joy_q;
      alt_d   = alt_q;
      sel_d   = sel_q;

      case (state_q)
         IDLE: begin
            if (enable_i) begin
               state_d = LOAD;
               div_d   = '0;
            end
         end
         LOAD: begin
            if (tick) begin
               state_d = SHIFT_LO;
               cnt_d   = '0;
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               cap_d = cap_shift;
               if (cnt_q == CNT_LAST) begin
                  state_d = COMMIT;
               end else begin
                  state_d = SHIFT_HI;
               end
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = SHIFT_LO;
            end
         end
         COMMIT: begin
            div_d = '0;
            if (sel_q) begin
               joy_d = cap_q ^ INV_MASK;
            end else begin
               alt_d = cap_q ^ INV_MASK;
            end
            if (SEL_MODE != 0) begin
               sel_d = ~sel_q;
            end
            state_d = enable_i ? SETTLE : IDLE;
         end
         SETTLE: begin
            if (tick) begin
               state_d = LOAD;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Pin outputs are decoded from the next state so they stay registered yet track the state.
      clk_d   = (state_d == SHIFT_HI);
      load_d  = (state_d != LOAD);
      frame_d = (state_d == COMMIT);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         cap_q   <= '0;
         joy_q   <= '1;
         alt_q   <= '1;
         clk_q   <= 1'b0;
         load_q  <= 1'b1;
         sel_q   <= 1'b1;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         cap_q   <= cap_d;
         joy_q   <= joy_d;
         alt_q   <= alt_d;
         clk_q   <= clk_d;
         load_q  <= load_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
      end
   end

   assign joy_clk_o  = clk_q;
   assign joy_load_o = load_q;
   assign joy_sel_o  = sel_q;
   assign joy_o      = joy_q;
   assign joy_alt_o  = alt_q;
   assign frame_o    = frame_q;

endmodule

// File: tb/tb_joy_chain_decoder.sv
// tb/tb_joy_chain_decoder.sv - self-checking bench for joy_chain_decoder
// Four configurations driven by behavioural shift-register chain models.
module tb_joy_chain_decoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;
   int   vec = 0;
   int   bad = 0;

   // a: plain, b: inverted, c: Sega multiplex, d: single bit
   logic        en_a = 1'b0, dat_a, jclk_a, load_a, sel_a, frm_a;
   logic [15:0] joy_a, alt_a;
   logic        en_b = 1'b0, dat_b, jclk_b, load_b, sel_b, frm_b;
   logic [15:0] joy_b, alt_b;
   logic        en_c = 1'b0, dat_c, jclk_c, load_c, sel_c, frm_c;
   logic [15:0] joy_c, alt_c;
   logic        en_d = 1'b0, dat_d, jclk_d, load_d, sel_d, frm_d;
   logic [0:0]  joy_d, alt_d;

   joy_chain_decoder #(.NUM_CH(2), .BITS_PER_CH(8), .CLK_DIV(4), .SEL_MODE(0), .INVERT(0)) u_a (
      .clk_i(clk), .reset_i(rst), .enable_i(en_a), .joy_data_i(dat_a), .joy_clk_o(jclk_a),
      .joy_load_o(load_a), .joy_sel_o(sel_a), .joy_o(joy_a), .joy_alt_o(alt_a), .frame_o(frm_a));
   joy_chain_decoder #(.NUM_CH(2), .BITS_PER_CH(8), .CLK_DIV(4), .SEL_MODE(0), .INVERT(1)) u_b (
      .clk_i(clk), .reset_i(rst), .enable_i(en_b), .joy_data_i(dat_b), .joy_clk_o(jclk_b),
      .joy_load_o(load_b), .joy_sel_o(sel_b), .joy_o(joy_b), .joy_alt_o(alt_b), .frame_o(frm_b));
   joy_chain_decoder #(.NUM_CH(2), .BITS_PER_CH(8), .CLK_DIV(4), .SEL_MODE(1), .INVERT(0)) u_c (
      .clk_i(clk), .reset_i(rst), .enable_i(en_c), .joy_data_i(dat_c), .joy_clk_o(jclk_c),
      .joy_load_o(load_c), .joy_sel_o(sel_c), .joy_o(joy_c), .joy_alt_o(alt_c), .frame_o(frm_c));
   joy_chain_decoder #(.NUM_CH(1), .BITS_PER_CH(1), .CLK_DIV(2), .SEL_MODE(0), .INVERT(0)) u_d (
      .clk_i(clk), .reset_i(rst), .enable_i(en_d), .joy_data_i(dat_d), .joy_clk_o(jclk_d),
      .joy_load_o(load_d), .joy_sel_o(sel_d), .joy_o(joy_d), .joy_alt_o(alt_d), .frame_o(frm_d));

   // Chain models: parallel load while load is low, shift on each rising shift clock.
   logic [15:0] word_a = '0, word_b = '0, word_c1 = '0, word_c0 = '0;
   logic [15:0] sr_a = '0, sr_b = '0, sr_c = '0;
   logic        word_d = 1'b0, sr_d = 1'b0;
   logic        pclk_a = 1'b0, pclk_b = 1'b0, pclk_c = 1'b0;
   int          d_hi = 0;

   always @(negedge clk) begin
      if (!load_a) sr_a = word_a; else if (jclk_a && !pclk_a) sr_a = sr_a << 1;
      if (!load_b) sr_b = word_b; else if (jclk_b && !pclk_b) sr_b = sr_b << 1;
      if (!load_c) sr_c = sel_c ? word_c1 : word_c0; else if (jclk_c && !pclk_c) sr_c = sr_c << 1;
      if (!load_d) sr_d = word_d;
      pclk_a = jclk_a;
      pclk_b = jclk_b;
      pclk_c = jclk_c;
      if (jclk_d) d_hi++;
   end

   assign dat_a = sr_a[15];
   assign dat_b = sr_b[15];
   assign dat_c = sr_c[15];
   assign dat_d = sr_d;

   function automatic logic frm_of(input int which);
      case (which)
         0: return frm_a;
         1: return frm_b;
         2: return frm_c;
         default: return frm_d;
      endcase
   endfunction

   task automatic wait_frame(input int which, input int budget, output int cycles);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frm_of(which) && n < budget);
      cycles = frm_of(which) ? n : -1;
   endtask

   task automatic do_reset();
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      vec++;
      if ({joy_a, alt_a, jclk_a, load_a, sel_a, frm_a} !== {16'hFFFF, 16'hFFFF, 4'b0110}) begin
         bad++;
         $display("FAIL reset_a: got %h %h %b%b%b%b, want ffff ffff 0110", joy_a, alt_a, jclk_a, load_a, sel_a, frm_a);
      end
      vec++;
      if ({joy_b, alt_b, jclk_b, load_b, sel_b, frm_b} !== {16'hFFFF, 16'hFFFF, 4'b0110}) begin
         bad++;
         $display("FAIL reset_b: got %h %h %b%b%b%b, want ffff ffff 0110", joy_b, alt_b, jclk_b, load_b, sel_b, frm_b);
      end
      vec++;
      if ({joy_c, alt_c, jclk_c, load_c, sel_c, frm_c} !== {16'hFFFF, 16'hFFFF, 4'b0110}) begin
         bad++;
         $display("FAIL reset_c: got %h %h %b%b%b%b, want ffff ffff 0110", joy_c, alt_c, jclk_c, load_c, sel_c, frm_c);
      end
      vec++;
      if ({joy_d, alt_d, jclk_d, load_d, sel_d, frm_d} !== 6'b110110) begin
         bad++;
         $display("FAIL reset_d: got %b%b%b%b%b%b, want 110110", joy_d, alt_d, jclk_d, load_d, sel_d, frm_d);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int cyc;
      do_reset();
      word_a = 16'hA53C;
      en_a = 1'b1;
      wait_frame(0, 400, cyc);
      vec++;
      if (cyc !== 129) begin bad++; $display("FAIL basic_latency: got %0d cycles, want 129", cyc); end
      @(negedge clk);
      vec++;
      if (frm_a !== 1'b0) begin bad++; $display("FAIL basic_strobe_width: frame_o still %b, want 0", frm_a); end
      vec++;
      if (joy_a !== 16'hA53C) begin bad++; $display("FAIL basic_data: got %h, want a53c", joy_a); end
      wait_frame(0, 400, cyc);
      vec++;
      if (cyc + 1 !== 133) begin bad++; $display("FAIL basic_period: got %0d cycles, want 133", cyc + 1); end
      vec++;
      if ({sel_a, alt_a} !== {1'b1, 16'hFFFF}) begin
         bad++;
         $display("FAIL sel0_hold: got sel=%b alt=%h, want sel=1 alt=ffff", sel_a, alt_a);
      end
   endtask

   task automatic test_random_frames();
      int cyc;
      logic [15:0] w;
      do_reset();
      w = 16'($urandom);
      word_a = w;
      en_a = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_frame(0, 400, cyc);
         if (k > 0) begin
            vec++;
            if (cyc + 1 !== 133) begin bad++; $display("FAIL rand_period[%0d]: got %0d, want 133", k, cyc + 1); end
         end
         @(negedge clk);
         vec++;
         if (joy_a !== w) begin bad++; $display("FAIL rand_data[%0d]: got %h, want %h", k, joy_a, w); end
         w = 16'($urandom);
         word_a = w;
      end
   endtask

   task automatic test_invert();
      int cyc;
      logic [15:0] pat [6];
      pat[0] = 16'h0000;
      pat[1] = 16'hFFFF;
      for (int i = 2; i < 6; i++) pat[i] = 16'($urandom);
      do_reset();
      word_b = pat[0];
      en_b = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_frame(1, 400, cyc);
         @(negedge clk);
         vec++;
         if (joy_b !== ~pat[k]) begin bad++; $display("FAIL invert[%0d]: got %h, want %h", k, joy_b, ~pat[k]); end
         if (k < 5) word_b = pat[k + 1];
      end
   endtask

   task automatic test_sel_mux();
      int cyc;
      logic [15:0] exp_joy, exp_alt;
      logic exp_sel;
      do_reset();
      exp_joy = 16'hFFFF;
      exp_alt = 16'hFFFF;
      word_c1 = 16'h1212;
      word_c0 = 16'h3434;
      en_c = 1'b1;
      for (int k = 0; k < 6; k++) begin
         // frames alternate sel starting at 1 after reset
         if (k % 2 == 0) exp_joy = word_c1; else exp_alt = word_c0;
         exp_sel = (k % 2 == 0) ? 1'b0 : 1'b1;
         wait_frame(2, 400, cyc);
         @(negedge clk);
         vec++;
         if ({joy_c, alt_c, sel_c} !== {exp_joy, exp_alt, exp_sel}) begin
            bad++;
            $display("FAIL sel_mux[%0d]: got joy=%h alt=%h sel=%b, want joy=%h alt=%h sel=%b",
                     k, joy_c, alt_c, sel_c, exp_joy, exp_alt, exp_sel);
         end
         if (k >= 1) begin
            word_c1 = 16'($urandom);
            word_c0 = 16'($urandom);
         end
      end
   endtask

   task automatic test_enable_drop();
      int cyc, rises, n, extra, idle_bad;
      logic prev;
      logic [15:0] w;
      do_reset();
      w = 16'($urandom);
      word_a = w;
      en_a = 1'b1;
      rises = 0; n = 0; prev = 1'b0;
      while (rises < 6 && n < 400) begin
         @(negedge clk);
         n++;
         if (jclk_a && !prev) rises++;
         prev = jclk_a;
      end
      en_a = 1'b0;
      wait_frame(0, 400, cyc);
      vec++;
      if (cyc < 0) begin bad++; $display("FAIL drop_commit: no frame_o within %0d cycles, want one", 400); end
      @(negedge clk);
      vec++;
      if (joy_a !== w) begin bad++; $display("FAIL drop_data: got %h, want %h", joy_a, w); end
      extra = 0; idle_bad = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (frm_a) extra++;
         if (jclk_a !== 1'b0 || load_a !== 1'b1) idle_bad++;
      end
      vec++;
      if (extra !== 0) begin bad++; $display("FAIL drop_extra_frames: got %0d, want 0", extra); end
      vec++;
      if (idle_bad !== 0) begin bad++; $display("FAIL drop_idle_pins: %0d bad cycles, want 0", idle_bad); end
   endtask

   task automatic test_reset_mid();
      int cyc, rises, n, leaks;
      logic prev;
      do_reset();
      word_a = 16'hA53C;
      en_a = 1'b1;
      wait_frame(0, 400, cyc);
      @(negedge clk);
      vec++;
      if (joy_a !== 16'hA53C) begin bad++; $display("FAIL mid_first: got %h, want a53c", joy_a); end
      word_a = 16'h5AC3;
      rises = 0; n = 0; leaks = 0; prev = 1'b0;
      while (rises < 10 && n < 400) begin
         @(negedge clk);
         n++;
         if (jclk_a && !prev) rises++;
         prev = jclk_a;
         if (joy_a !== 16'hA53C || frm_a) leaks++;
      end
      while (jclk_a && n < 400) begin
         @(negedge clk);
         n++;
      end
      vec++;
      if (leaks !== 0) begin bad++; $display("FAIL mid_partial_visible: %0d bad cycles, want 0", leaks); end
      rst = 1'b1;
      @(negedge clk);
      vec++;
      if ({joy_a, frm_a, load_a, jclk_a} !== {16'hFFFF, 3'b010}) begin
         bad++;
         $display("FAIL mid_reset_state: got %h %b%b%b, want ffff 010", joy_a, frm_a, load_a, jclk_a);
      end
      rst = 1'b0;
      @(negedge clk);
      vec++;
      if (load_a !== 1'b0) begin bad++; $display("FAIL mid_reload: load=%b, want 0", load_a); end
      wait_frame(0, 400, cyc);
      vec++;
      if (cyc !== 128) begin bad++; $display("FAIL mid_latency: got %0d, want 128", cyc); end
      @(negedge clk);
      vec++;
      if (joy_a !== 16'h5AC3) begin bad++; $display("FAIL mid_next_data: got %h, want 5ac3", joy_a); end
   endtask

   task automatic test_single_bit();
      int cyc, hi0;
      logic w;
      do_reset();
      hi0 = d_hi;
      w = 1'b1;
      word_d = w;
      en_d = 1'b1;
      wait_frame(3, 50, cyc);
      vec++;
      if (cyc !== 5) begin bad++; $display("FAIL n1_latency: got %0d, want 5", cyc); end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         vec++;
         if (joy_d !== w) begin bad++; $display("FAIL n1_data[%0d]: got %b, want %b", k, joy_d, w); end
         w = (k == 0) ? 1'b0 : 1'($urandom);
         word_d = w;
         wait_frame(3, 50, cyc);
         vec++;
         if (cyc + 1 !== 7) begin bad++; $display("FAIL n1_period[%0d]: got %0d, want 7", k, cyc + 1); end
      end
      vec++;
      if (d_hi - hi0 !== 0) begin bad++; $display("FAIL n1_clk_high: %0d high cycles, want 0", d_hi - hi0); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random_frames();
      test_invert();
      test_sel_mux();
      test_enable_drop();
      test_reset_mid();
      test_single_bit();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/joy_chain_decoder.md
JOY_CHAIN_DECODER -- requirements
Module: joy_chain_decoder

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of joystick channels in the serial chain, range 1..4.
REQ-002 SHALL have parameter BITS_PER_CH, default 8: bits per channel, range 1..16.
REQ-003 SHALL have parameter CLK_DIV, default 16: clk_i cycles per half-period of the shift clock, minimum 2.
REQ-004 SHALL have parameter SEL_MODE, default 0: 0 holds the select output high, 1 alternates it each frame (Sega multiplex).
REQ-005 SHALL have parameter INVERT, default 0: 1 inverts the captured bits before they are committed.
REQ-006 clk_i  in  1  system clock; the sole clock; every register is clocked on the rising edge.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 enable_i  in  1  1 starts or continues scanning; 0 returns to IDLE once the current frame is complete.
REQ-009 joy_data_i  in  1  serial data from the shift-register chain.
REQ-010 joy_clk_o  out  1  shift clock to the chain.
REQ-011 joy_load_o  out  1  active-low parallel load to the chain.
REQ-012 joy_sel_o  out  1  select line to the joystick ports.
REQ-013 joy_o  out  NUM_CH*BITS_PER_CH  last frame captured with sel=1.
REQ-014 joy_alt_o  out  NUM_CH*BITS_PER_CH  last frame captured with sel=0.
REQ-015 frame_o  out  1  one-cycle strobe marking a commit.

Function
REQ-016 Let N = NUM_CH*BITS_PER_CH. A tick is the cycle in which the divider counter, counting 0..CLK_DIV-1, reads CLK_DIV-1.
REQ-017 The divider SHALL clear on IDLE->LOAD and in COMMIT, and SHALL otherwise run freely.
REQ-018 States SHALL be IDLE, LOAD, SHIFT_LO, SHIFT_HI, COMMIT and SETTLE.
REQ-019 IDLE: joy_clk_o=0, joy_load_o=1; go to LOAD on the first cycle with enable_i=1.
REQ-020 LOAD: joy_load_o=0, joy_clk_o=0; on tick, go to SHIFT_LO with bit count 0.
REQ-021 SHIFT_LO: joy_clk_o=0, joy_load_o=1; on tick, shift joy_data_i into the capture register LSB, shifting existing bits toward the MSB.
REQ-022 SHIFT_LO on tick SHALL then go to COMMIT if bit count = N-1, otherwise to SHIFT_HI.
REQ-023 SHIFT_HI: joy_clk_o=1; on tick, increment the bit count and go to SHIFT_LO.
REQ-024 The first bit received SHALL end in bit N-1; channel c SHALL occupy bits [c*BITS_PER_CH +: BITS_PER_CH].
REQ-025 COMMIT SHALL last exactly one cycle and SHALL assert frame_o=1 in that cycle.
REQ-026 In COMMIT, the capture value (XOR all-ones if INVERT=1) SHALL be written to joy_o if joy_sel_o=1, otherwise to joy_alt_o; the other output SHALL hold its value.
REQ-027 In COMMIT with SEL_MODE=1, joy_sel_o SHALL toggle.
REQ-028 COMMIT SHALL go to SETTLE if enable_i=1, otherwise to IDLE.
REQ-029 SETTLE: joy_clk_o=0, joy_load_o=1 for one tick period (lets sel settle); on tick, go to LOAD.
REQ-030 Frame period SHALL be CLK_DIV*(2N+1)+1 clk_i cycles, measured COMMIT to COMMIT.
REQ-031 Outputs SHALL change only in COMMIT; a partial capture SHALL never be visible.
REQ-032 Deasserting enable_i mid-frame SHALL NOT abort the frame; the frame SHALL complete and commit, then the block enters IDLE.
REQ-033 With SEL_MODE=0, joy_sel_o SHALL stay 1 and joy_alt_o SHALL keep its reset value.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 With reset_i=1 at a clock edge, the block SHALL enter IDLE and reset the divider and bit count.
REQ-036 On reset: joy_o and joy_alt_o all ones, joy_clk_o=0, joy_load_o=1, joy_sel_o=1, frame_o=0.
REQ-037 Reset mid-frame SHALL discard the partial capture without a commit.
REQ-038 Reset SHALL take priority over enable_i.

Verification
REQ-039 NUM_CH=2, BITS=8, CLK_DIV=4; serial stream A5h then 3Ch, MSB first -> joy_o=16'hA53C; frame_o one cycle; strobes 133 cycles apart.
REQ-040 Same configuration, INVERT=1, stream all zeros -> joy_o=16'hFFFF; stream FFFFh -> joy_o=16'h0000.
REQ-041 SEL_MODE=1: model returns 12h when sel=1 and 34h when sel=0 -> joy_o=..12, joy_alt_o=..34; joy_sel_o alternates on each strobe.
REQ-042 enable_i dropped during SHIFT_HI of bit 5 -> frame completes, frame_o pulses once, then IDLE with joy_load_o=1 and joy_clk_o=0 held.
REQ-043 reset_i pulsed during SHIFT_LO of bit 10 after a committed A53Ch -> outputs return to FFFFh, no frame_o, and on re-enable the first LOAD starts on the next cycle.
REQ-044 N=1 (NUM_CH=1, BITS=1), CLK_DIV=2 -> no SHIFT_HI state visited, period 7 cycles, joy_clk_o never high.
